// File: rtl/charlie_pkg.sv
// Shared helpers for the Charlieplex scanner: width math and the LED -> pin-pair map.
package charlie_pkg;

  typedef struct packed {
    int   h;
    int   l;
    logic pol;
  } led_pins_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int leds_from_pins(input int pins);
    return pins * (pins - 1);
  endfunction

  // Pair k walks h = pins-1..1, l = h-1..0; even LEDs pull h low, odd LEDs pull h high.
  function automatic led_pins_t led_map(input int idx, input int pins);
    led_pins_t r;
    int k;
    r = '{h: 0, l: 0, pol: 1'b0};
    k = 0;
    for (int h = pins - 1; h >= 1; h--) begin
      for (int l = h - 1; l >= 0; l--) begin
        if (k == idx / 2) begin
          r.h = h;
          r.l = l;
        end
        k++;
      end
    end
    r.pol = (idx % 2) == 1;
    return r;
  endfunction

endpackage

// File: rtl/charlie_pwm_bank.sv
// Double-buffered brightness store: writes land in the back bank, reads come from the front.
module charlie_pwm_bank
  import charlie_pkg::*;
#(
  parameter int LEDS     = 56,
  parameter int PWM_BITS = 4,
  parameter int AW       = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                swap,
  input  logic [AW-1:0]       rd_addr,
  output logic [PWM_BITS-1:0] rd_level
);

  logic                bank_sel_reg;
  logic [PWM_BITS-1:0] mem0 [LEDS];
  logic [PWM_BITS-1:0] mem1 [LEDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_sel_reg <= 1'b0;
    else if (swap) bank_sel_reg <= ~bank_sel_reg;
  end

  // Back bank is the one not selected; a write on the swap cycle uses the old selection.
  for (genvar gi = 0; gi < LEDS; gi++) begin : g_led
    logic [PWM_BITS-1:0] lvl0_reg;
    logic [PWM_BITS-1:0] lvl1_reg;
    logic                hit;

    assign hit = wr_en && (wr_addr == AW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl0_reg <= '0;
        lvl1_reg <= '0;
      end else if (hit) begin
        if (bank_sel_reg) lvl0_reg <= wr_data;
        else lvl1_reg <= wr_data;
      end
    end

    assign mem0[gi] = lvl0_reg;
    assign mem1[gi] = lvl1_reg;
  end

  assign rd_level = bank_sel_reg ? mem1[rd_addr] : mem0[rd_addr];

endmodule

// File: rtl/charlie_pwm_scan.sv
// Charlieplexed LED scanner with per-LED PWM, dead time and tear-free frame swap.
module charlie_pwm_scan
  import charlie_pkg::*;
#(
  parameter int PINS     = 8,
  parameter int PWM_BITS = 4,
  parameter int TICK_DIV = 375,
  parameter int DEAD     = 16,
  localparam int LEDS    = leds_from_pins(PINS),
  localparam int AW      = clog2(LEDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                swap_req,
  output logic                swap_pending,
  output logic                frame_start,
  output logic [PINS-1:0]     pin_oe,
  output logic [PINS-1:0]     pin_out
);

  localparam int DW = clog2(DEAD);
  localparam int VW = clog2(TICK_DIV);

  logic                dead_reg;
  logic [DW-1:0]       dead_cnt_reg;
  logic [VW-1:0]       div_cnt_reg;
  logic [PWM_BITS-1:0] tick_reg;
  logic [AW-1:0]       slot_reg;
  logic                swap_pending_reg;
  logic                frame_start_reg;
  logic [PINS-1:0]     pin_oe_reg;
  logic [PINS-1:0]     pin_out_reg;

  logic                tick_end, slot_end, boundary, do_swap, drive;
  logic [PWM_BITS-1:0] level;
  logic [PINS-1:0]     oe_pat  [LEDS];
  logic [PINS-1:0]     out_pat [LEDS];

  for (genvar gi = 0; gi < LEDS; gi++) begin : g_map
    localparam led_pins_t MAP = led_map(gi, PINS);
    assign oe_pat[gi]  = (PINS'(1) << MAP.h) | (PINS'(1) << MAP.l);
    assign out_pat[gi] = PINS'(1) << (MAP.pol ? MAP.h : MAP.l);
  end

  assign tick_end = !dead_reg && (div_cnt_reg == VW'(TICK_DIV - 1));
  assign slot_end = tick_end && (tick_reg == '1);
  assign boundary = enable && slot_end && (slot_reg == AW'(LEDS - 1));
  assign do_swap  = (swap_pending_reg || swap_req) && (boundary || !enable);
  assign drive    = enable && !dead_reg && (tick_reg < level);

  charlie_pwm_bank #(
    .LEDS     (LEDS),
    .PWM_BITS (PWM_BITS),
    .AW       (AW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .swap     (do_swap),
    .rd_addr  (slot_reg),
    .rd_level (level)
  );

  // Each slot opens with a dead phase, then 2^PWM_BITS sub-ticks of TICK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      if (!rst_n || !enable) begin
        dead_reg     <= 1'b1;
        dead_cnt_reg <= '0;
        div_cnt_reg  <= '0;
        tick_reg     <= '0;
        slot_reg     <= '0;
      end
    end else if (dead_reg) begin
      if (dead_cnt_reg == DW'(DEAD - 1)) begin
        dead_reg     <= 1'b0;
        dead_cnt_reg <= '0;
      end else begin
        dead_cnt_reg <= dead_cnt_reg + 1'b1;
      end
    end else if (tick_end) begin
      div_cnt_reg <= '0;
      if (slot_end) begin
        tick_reg <= '0;
        dead_reg <= 1'b1;
        slot_reg <= (slot_reg == AW'(LEDS - 1)) ? '0 : slot_reg + 1'b1;
      end else begin
        tick_reg <= tick_reg + 1'b1;
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pending_reg <= 1'b0;
      frame_start_reg  <= 1'b0;
      pin_oe_reg       <= '0;
      pin_out_reg      <= '0;
    end else begin
      swap_pending_reg <= do_swap ? 1'b0 : (swap_pending_reg || swap_req);
      frame_start_reg  <= enable && dead_reg && (dead_cnt_reg == '0) && (slot_reg == '0);
      pin_oe_reg       <= drive ? oe_pat[slot_reg] : '0;
      pin_out_reg      <= drive ? out_pat[slot_reg] : '0;
    end
  end

  assign swap_pending = swap_pending_reg;
  assign frame_start  = frame_start_reg;
  assign pin_oe       = pin_oe_reg;
  assign pin_out      = pin_out_reg;

endmodule

// File: tb/tb_charlie_pwm_scan.sv
// Randomised bench for charlie_pwm_scan against a frame-position model of the scan.
module tb_charlie_pwm_scan;

  localparam int PINS     = 3;
  localparam int PWM_BITS = 2;
  localparam int TICK_DIV = 2;
  localparam int DEAD     = 1;
  localparam int LEDS     = PINS * (PINS - 1);
  localparam int SLOT     = DEAD + (1 << PWM_BITS) * TICK_DIV;
  localparam int FRAME    = LEDS * SLOT;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                wr_en = 1'b0;
  logic [2:0]          wr_addr = '0;
  logic [PWM_BITS-1:0] wr_data = '0;
  logic                swap_req = 1'b0;
  logic                swap_pending, frame_start;
  logic [PINS-1:0]     pin_oe, pin_out;

  int checks = 0;
  int errors = 0;

  int m_front[LEDS];
  int m_back[LEDS];
  bit m_pend;
  int m_pos;
  int pat_oe[LEDS];
  int pat_out[LEDS];
  int exp_oe, exp_out, exp_fs, exp_pend;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  charlie_pwm_scan #(
    .PINS(PINS), .PWM_BITS(PWM_BITS), .TICK_DIV(TICK_DIV), .DEAD(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
    .frame_start(frame_start), .pin_oe(pin_oe), .pin_out(pin_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LEDS; i++) begin
      m_front[i] = 0;
      m_back[i]  = 0;
    end
    m_pend = 0; m_pos = 0;
    exp_oe = 0; exp_out = 0; exp_fs = 0; exp_pend = 0;
  endtask

  // Expected registered outputs follow from where we sit in the frame before this edge.
  task automatic model_step();
    int slot, c, tick, tmp;
    bit pend_or, bnd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_oe = 0; exp_out = 0; exp_fs = 0;
    if (enable) begin
      slot = m_pos / SLOT;
      c    = m_pos % SLOT;
      exp_fs = (m_pos == 0);
      if (c >= DEAD) begin
        tick = (c - DEAD) / TICK_DIV;
        if (tick < m_front[slot]) begin
          exp_oe  = pat_oe[slot];
          exp_out = pat_out[slot];
        end
      end
    end
    bnd = enable && (m_pos == FRAME - 1);
    pend_or = m_pend || swap_req;
    if (wr_en && int'(wr_addr) < LEDS) m_back[int'(wr_addr)] = int'(wr_data);
    if (pend_or && (bnd || !enable)) begin
      for (int i = 0; i < LEDS; i++) begin
        tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
      end
      m_pend = 0;
    end else begin
      m_pend = pend_or;
    end
    exp_pend = m_pend;
    m_pos = enable ? (m_pos + 1) % FRAME : 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pin_oe", int'(pin_oe), exp_oe);
      chk("pin_out", int'(pin_out), exp_out);
      chk("frame_start", int'(frame_start), exp_fs);
      chk("swap_pending", int'(swap_pending), exp_pend);
      chk("oe_popcount_0_or_2", int'($countones(pin_oe) == 0 || $countones(pin_oe) == 2), 1);
    end
  end

  task automatic cyc(input logic en, input logic we, input int wa, input int wd, input logic sr);
    enable = en; wr_en = we; wr_addr = 3'(wa); wr_data = PWM_BITS'(wd); swap_req = sr;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wait_fs();
    int i;
    i = 0;
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    while (frame_start !== 1'b1 && i < 200) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      i++;
    end
    chk("wait_frame_start", int'(frame_start), 1);
  endtask

  task automatic seg(input string name, input int n, input int oe, input int out);
    for (int i = 0; i < n; i++) begin
      chk({name, "_oe"}, int'(pin_oe), oe);
      chk({name, "_out"}, int'(pin_out), out);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic wait_pos(input int p);
    int i;
    i = 0;
    while (m_pos != p && i < 200) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      i++;
    end
  endtask

  initial begin
    int k, fs_cnt, oe_nz, i;
    k = 0;
    for (int h = PINS - 1; h >= 1; h--) begin
      for (int l = h - 1; l >= 0; l--) begin
        pat_oe[2*k]    = (1 << h) | (1 << l);
        pat_out[2*k]   = 1 << l;
        pat_oe[2*k+1]  = (1 << h) | (1 << l);
        pat_out[2*k+1] = 1 << h;
        k++;
      end
    end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_pin_oe", int'(pin_oe), 0);
    chk("reset_swap_pending", int'(swap_pending), 0);
    rst_n = 1'b1;

    // All levels zero: dark for two frames, one frame_start per frame.
    fs_cnt = 0; oe_nz = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      fs_cnt += int'(frame_start);
      oe_nz  += int'(pin_oe != 0);
    end
    chk("idle_frame_starts", fs_cnt, 2);
    chk("idle_oe_active", oe_nz, 0);

    // LED0 at max level.
    cyc(1'b1, 1'b1, 0, 3, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    chk("pending_after_req", int'(swap_pending), 1);
    wait_fs();
    seg("led0_dead", 1, 3'b000, 3'b000);
    seg("led0_on", 6, 3'b110, 3'b010);
    seg("led0_dark", 2, 3'b000, 3'b000);

    // LED1=1 and LED5=2; new front has LED0 back at 0.
    cyc(1'b1, 1'b1, 1, 1, 1'b0);
    cyc(1'b1, 1'b1, 5, 2, 1'b1);
    wait_fs();
    seg("slot0_off", SLOT, 3'b000, 3'b000);
    seg("led1_dead", 1, 3'b000, 3'b000);
    seg("led1_on", 2, 3'b110, 3'b100);
    seg("led1_dark", 6 + 3 * SLOT, 3'b000, 3'b000);
    seg("led5_dead", 1, 3'b000, 3'b000);
    seg("led5_on", 4, 3'b011, 3'b010);
    seg("led5_dark", 4, 3'b000, 3'b000);

    // Mid-frame swap with back-bank writes and a repeated request.
    wait_pos(FRAME / 2);
    for (int a = 0; a < LEDS; a++) cyc(1'b1, 1'b1, a, $urandom_range(0, 3), a == 0 || a == 3);
    chk("pending_mid_frame", int'(swap_pending), 1);
    idle(2 * FRAME);

    // Request landing exactly on the boundary cycle.
    wait_pos(FRAME - 1);
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    chk("boundary_swap_no_pending", int'(swap_pending), 0);
    idle(FRAME);

    // Out-of-range addresses are dropped.
    cyc(1'b1, 1'b1, 6, 3, 1'b0);
    cyc(1'b1, 1'b1, 7, 3, 1'b1);
    idle(2 * FRAME);

    // Random traffic, including short enable drops.
    for (int c = 0; c < 2000; c++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 3), $urandom_range(0, 7),
          $urandom_range(0, 3), ($urandom_range(0, 39) == 0));
    end

    // Enable drop while driving, then restart.
    for (int a = 0; a < LEDS; a++) cyc(1'b1, 1'b1, a, 3, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    idle(2 * FRAME);
    i = 0;
    while (pin_oe == 0 && i < 100) begin cyc(1'b1, 1'b0, 0, 0, 1'b0); i++; end
    chk("driving_before_disable", int'(pin_oe != 0), 1);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    chk("disable_oe", int'(pin_oe), 0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    chk("reenable_frame_start", int'(frame_start), 1);

    // Asynchronous reset while driving.
    i = 0;
    while (pin_oe == 0 && i < 100) begin cyc(1'b1, 1'b0, 0, 0, 1'b0); i++; end
    chk("driving_before_reset", int'(pin_oe != 0), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_oe", int'(pin_oe), 0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    chk("post_reset_frame_start", int'(frame_start), 1);
    idle(FRAME);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
